// File: rtl/bomber_pkg.sv
// Shared types and clamped life arithmetic for the player health blocks.
package bomber_pkg;

    localparam int LIFE_W           = 7;
    localparam int LIFE_MAX_DEFAULT = 100;
    localparam int CNT_W            = 8;

    typedef enum logic [1:0] {
        LS_ALIVE  = 2'd0,
        LS_INVULN = 2'd1,
        LS_DEAD   = 2'd2
    } life_state_t;

    function automatic logic [7:0] sat_sub_life(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : 8'd0;
    endfunction

    // Sum is formed in 9 bits so the clamp can never see a wrapped value.
    function automatic logic [7:0] sat_add_life(input logic [7:0] a, input logic [7:0] b,
                                                input logic [7:0] max_v);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max_v}) ? max_v : s[7:0];
    endfunction

endpackage

// File: rtl/frame_countdown.sv
// Loadable down-counter stepped by frame_tick; stops at zero.
module frame_countdown
    import bomber_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_tick,
    output logic [W-1:0] o_count,
    output logic [W-1:0] o_count_nxt,
    output logic         o_zero
);

    logic [W-1:0] r_count;
    logic [W-1:0] w_count_nxt;

    always_comb begin
        w_count_nxt = r_count;
        if (i_clear)
            w_count_nxt = '0;
        else if (i_load)
            w_count_nxt = i_load_val;
        else if (i_tick && (r_count != '0))
            w_count_nxt = r_count - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_count <= '0;
        else
            r_count <= w_count_nxt;
    end

    assign o_count     = r_count;
    assign o_count_nxt = w_count_nxt;
    assign o_zero      = (r_count == '0);

endmodule

// File: rtl/player_life.sv
// Per-player health manager: damage, heals, post-hit invulnerability, regen, death.
module player_life
    import bomber_pkg::*;
#(
    parameter int LIFE_MAX      = LIFE_MAX_DEFAULT,
    parameter int INVULN_FRAMES = 60,
    parameter int REGEN_PERIOD  = 120,
    parameter int BLINK_SHIFT   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              game_start,
    input  logic              frame_tick,
    input  logic              hit,
    input  logic [LIFE_W-1:0] damage,
    input  logic              heal,
    input  logic [LIFE_W-1:0] heal_amount,
    output logic [LIFE_W-1:0] life,
    output logic              dead,
    output logic              invincible,
    output logic              blink
);

    localparam logic [7:0]        MAX8     = 8'(LIFE_MAX);
    localparam logic [LIFE_W-1:0] MAX7     = LIFE_W'(LIFE_MAX);
    localparam logic [7:0]        INV_LOAD = (INVULN_FRAMES == 0) ? 8'd1 : 8'(INVULN_FRAMES);
    localparam logic [7:0]        REGEN_P  = 8'(REGEN_PERIOD);

    life_state_t       r_state;
    logic [7:0]        r_life_cur;
    logic [7:0]        r_regen_cnt;
    logic [LIFE_W-1:0] r_life;
    logic              r_dead;
    logic              r_inv;
    logic              r_blink;

    logic [7:0]   w_hit_life;
    logic [7:0]   w_heal_life;
    logic [7:0]   w_regen_inc;
    logic         w_regen_step;
    logic         w_inv_load;
    logic         w_inv_tick;
    logic         w_inv_done;
    logic [CNT_W-1:0] w_inv_cnt;
    logic [CNT_W-1:0] w_inv_cnt_nxt;
    logic         w_inv_zero;

    assign w_hit_life   = sat_sub_life(r_life_cur, {1'b0, damage});
    assign w_heal_life  = heal ? sat_add_life(r_life_cur, {1'b0, heal_amount}, MAX8) : r_life_cur;
    assign w_regen_inc  = r_regen_cnt + 8'd1;
    assign w_regen_step = (REGEN_PERIOD != 0) && frame_tick && (w_regen_inc == REGEN_P);
    assign w_inv_load   = !game_start && (r_state == LS_ALIVE) && hit && (w_hit_life != 8'd0);
    assign w_inv_tick   = !game_start && (r_state == LS_INVULN) && frame_tick;
    // The expiring tick is the one that walks the counter from 1 down to 0.
    assign w_inv_done   = w_inv_zero || (w_inv_tick && (w_inv_cnt_nxt == '0));

    frame_countdown #(.W(CNT_W)) u_inv_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_clear     (game_start),
        .i_load      (w_inv_load),
        .i_load_val  (INV_LOAD),
        .i_tick      (w_inv_tick),
        .o_count     (w_inv_cnt),
        .o_count_nxt (w_inv_cnt_nxt),
        .o_zero      (w_inv_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= LS_ALIVE;
            r_life_cur  <= MAX8;
            r_regen_cnt <= 8'd0;
            r_life      <= MAX7;
            r_dead      <= 1'b0;
            r_inv       <= 1'b0;
            r_blink     <= 1'b0;
        end else if (game_start) begin
            r_state     <= LS_ALIVE;
            r_life_cur  <= MAX8;
            r_regen_cnt <= 8'd0;
            r_life      <= MAX7;
            r_dead      <= 1'b0;
            r_inv       <= 1'b0;
            r_blink     <= 1'b0;
        end else begin
            // Display samples the pre-update value so the bar only moves on frame edges.
            if (frame_tick)
                r_life <= r_life_cur[LIFE_W-1:0];
            case (r_state)
                LS_ALIVE: begin
                    if (hit) begin
                        r_regen_cnt <= 8'd0;
                        if (w_hit_life == 8'd0) begin
                            r_state    <= LS_DEAD;
                            r_life_cur <= 8'd0;
                            r_dead     <= 1'b1;
                            r_inv      <= 1'b0;
                            r_blink    <= 1'b0;
                        end else begin
                            r_state    <= LS_INVULN;
                            r_life_cur <= w_hit_life;
                            r_inv      <= 1'b1;
                            r_blink    <= w_inv_cnt_nxt[BLINK_SHIFT];
                        end
                    end else begin
                        if (w_regen_step && (w_heal_life < MAX8))
                            r_life_cur <= w_heal_life + 8'd1;
                        else
                            r_life_cur <= w_heal_life;
                        if (frame_tick && (REGEN_PERIOD != 0))
                            r_regen_cnt <= w_regen_step ? 8'd0 : w_regen_inc;
                    end
                end
                LS_INVULN: begin
                    r_life_cur  <= w_heal_life;
                    r_regen_cnt <= 8'd0;
                    if (w_inv_done) begin
                        r_state <= LS_ALIVE;
                        r_inv   <= 1'b0;
                        r_blink <= 1'b0;
                    end else begin
                        r_inv   <= 1'b1;
                        r_blink <= w_inv_cnt_nxt[BLINK_SHIFT];
                    end
                end
                LS_DEAD: begin
                    r_life_cur  <= 8'd0;
                    r_regen_cnt <= 8'd0;
                    r_dead      <= 1'b1;
                    r_inv       <= 1'b0;
                    r_blink     <= 1'b0;
                end
                default: begin
                    r_state <= LS_ALIVE;
                    r_dead  <= 1'b0;
                    r_inv   <= 1'b0;
                    r_blink <= 1'b0;
                end
            endcase
        end
    end

    assign life       = r_life;
    assign dead       = r_dead;
    assign invincible = r_inv;
    assign blink      = r_blink;

endmodule
